ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_host_tx_if.sv | 19 +
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_host_tx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes and the parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RELEASE,
      ST_SHIFT,
      ST_WAIT_IDLE,
      ST_FAIL
   } Ps2TxState;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;

   // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the keyboard controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       busy;
   logic       tx_done;
   logic       tx_err;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, busy, tx_done, tx_err
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, busy, tx_done, tx_err
   );
endinterface

// File: rtl/ps2_line_sync.sv
// Synchroniser for the raw PS/2 clock and data lines with a registered clock falling-edge strobe.
module ps2_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic sys_rst_n,
   input  logic clk_raw,
   input  logic data_raw,
   output logic clk_sync,
   output logic data_sync,
   output logic clk_fall
);
   logic [SYNC_STAGES-1:0] clk_sr;
   logic [SYNC_STAGES-1:0] data_sr;
   logic                   clk_prev;

   // Idle PS/2 lines float high, so reset to 1 to avoid a false edge on release.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         clk_sr   <= '1;
         data_sr  <= '1;
         clk_prev <= 1'b1;
         clk_fall <= 1'b0;
      end else begin
         clk_sr   <= {clk_sr[SYNC_STAGES-2:0], clk_raw};
         data_sr  <= {data_sr[SYNC_STAGES-2:0], data_raw};
         clk_prev <= clk_sr[SYNC_STAGES-1];
         clk_fall <= clk_prev & ~clk_sr[SYNC_STAGES-1];
      end
   end

   assign clk_sync  = clk_sr[SYNC_STAGES-1];
   assign data_sync = data_sr[SYNC_STAGES-1];
endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, start, 8 data bits, odd parity, stop, ACK check.
// Build macro PS2_HOST_TX_RETRY_EN: retry the same byte once after the first NACK or timeout.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int INHIBIT_US  = 120,
   parameter int TIMEOUT_US  = 15000,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         sys_rst_n,
   ps2_host_tx_if.slave host,
   input  logic         ps2_clk_in,
   input  logic         ps2_data_in,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe
);
   // state        | meaning
   // ST_IDLE      | ready for a command byte
   // ST_INHIBIT   | clock held low INH cycles, start bit on the last one
   // ST_RELEASE   | clock released, start bit still driven, timers armed
   // ST_SHIFT     | one bit per device falling edge, ACK sampled on edge 11
   // ST_WAIT_IDLE | ACK seen, waiting for both lines high
   // ST_FAIL      | lines released, NACK or timeout reported (or retried)

   localparam int INH   = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
   localparam int TMO   = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
   localparam int INH_W = (INH > 1) ? $clog2(INH) : 1;
   localparam int TMO_W = $clog2(TMO + 1);

   Ps2TxState        state;
   Ps2TxState        state_nxt;
   logic [7:0]       tx_byte;
   logic             parity;
   logic [INH_W-1:0] inh_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [3:0]       bit_cnt;
   logic [2:0]       bit_idx;
   logic             run_q;
   logic             done_q;
   logic             clk_sync;
   logic             data_sync;
   logic             clk_fall;
   logic             accept;
   logic             inh_last;
   logic             tmo_hit;
   logic             retry_go;
   logic             shift_bit;

   ps2_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .clk_raw   (ps2_clk_in),
      .data_raw  (ps2_data_in),
      .clk_sync  (clk_sync),
      .data_sync (data_sync),
      .clk_fall  (clk_fall)
   );

   assign accept   = (state == ST_IDLE) && run_q && host.tx_valid;
   assign inh_last = (inh_cnt == '0);
   assign tmo_hit  = (tmo_cnt == TMO_W'(TMO));
   assign bit_idx  = 3'(bit_cnt - 4'd1);

`ifdef PS2_HOST_TX_RETRY_EN
   logic retry_q;

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         retry_q <= 1'b0;
      else if (state == ST_IDLE)
         retry_q <= 1'b0;
      else if (retry_go)
         retry_q <= 1'b1;
   end

   assign retry_go = (state == ST_FAIL) && !retry_q;
`else
   assign retry_go = 1'b0;
`endif

   // Line value for the current bit: start, LSB-first data, parity, then released for stop/ACK.
   always_comb begin
      shift_bit = 1'b0;
      if (bit_cnt == 4'd0)
         shift_bit = 1'b1;
      else if (bit_cnt <= 4'd8)
         shift_bit = ~tx_byte[bit_idx];
      else if (bit_cnt == 4'd9)
         shift_bit = ~parity;
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept)
               state_nxt = ST_INHIBIT;
         end
         ST_INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (inh_last) begin
               ps2_data_oe = 1'b1;
               state_nxt   = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            ps2_data_oe = 1'b1;
            state_nxt   = ST_SHIFT;
         end
         ST_SHIFT: begin
            ps2_data_oe = shift_bit;
            if (tmo_hit)
               state_nxt = ST_FAIL;
            else if (clk_fall && (bit_cnt == 4'd10))
               state_nxt = data_sync ? ST_FAIL : ST_WAIT_IDLE;
         end
         ST_WAIT_IDLE: begin
            if (tmo_hit)
               state_nxt = ST_FAIL;
            else if (clk_sync && data_sync)
               state_nxt = ST_IDLE;
         end
         ST_FAIL: begin
            state_nxt = retry_go ? ST_INHIBIT : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // tmo_cnt counts the release cycle as 1, so FAIL lands exactly TMO cycles after release.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         run_q   <= 1'b0;
         done_q  <= 1'b0;
         tx_byte <= '0;
         parity  <= 1'b0;
         inh_cnt <= '0;
         tmo_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         run_q  <= 1'b1;
         done_q <= (state == ST_WAIT_IDLE) && (state_nxt == ST_IDLE);
         if (accept) begin
            tx_byte <= host.tx_data;
            parity  <= odd_parity(host.tx_data);
         end
         if (accept || retry_go)
            inh_cnt <= INH_W'(INH - 1);
         else if ((state == ST_INHIBIT) && !inh_last)
            inh_cnt <= inh_cnt - 1'b1;
         if (state == ST_INHIBIT) begin
            tmo_cnt <= TMO_W'(1);
            bit_cnt <= '0;
         end else if (state inside {ST_RELEASE, ST_SHIFT, ST_WAIT_IDLE}) begin
            if (!tmo_hit)
               tmo_cnt <= tmo_cnt + 1'b1;
            if ((state == ST_SHIFT) && clk_fall && (bit_cnt != 4'd11))
               bit_cnt <= bit_cnt + 4'd1;
         end
      end
   end

   assign host.tx_ready = (state == ST_IDLE) && run_q;
   assign host.busy     = (state != ST_IDLE);
   assign host.tx_done  = done_q;
   assign host.tx_err   = (state == ST_FAIL) && !retry_go;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model (40-cycle device clock).
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 120;
   localparam int TMO  = 2000;
   localparam int HALF = 20;

   logic clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic ps2_clk_oe, ps2_data_oe;
   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;
   logic clk_line, data_line;

   assign clk_line  = dev_clk & ~ps2_clk_oe;
   assign data_line = dev_data & ~ps2_data_oe;

   ps2_host_tx_if host ();

   ps2_host_tx #(
      .CLK_FREQ_HZ (1000000),
      .INHIBIT_US  (120),
      .TIMEOUT_US  (2000),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .sys_rst_n   (sys_rst_n),
      .host        (host),
      .ps2_clk_in  (clk_line),
      .ps2_data_in (data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Passive monitor: pulse counts, inhibit run lengths, event timestamps.
   int cyc = 0;
   int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
   logic done_busy = 1'b0;
   logic [1:0] err_oe = 2'b00;
   int run_len = 0, data_hi = 0, inh_len = 0, inh_hi = 0, inh_runs = 0;
   int inh_start_cyc = 0, release_cyc = 0;
   logic last_data = 1'b0, inh_last = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (host.tx_done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_busy = host.busy;
      end
      if (host.tx_err) begin
         err_cnt++;
         err_cyc = cyc;
         err_oe  = {ps2_clk_oe, ps2_data_oe};
      end
      if (ps2_clk_oe) begin
         if (run_len == 0) inh_start_cyc = cyc;
         run_len++;
         last_data = ps2_data_oe;
         if (ps2_data_oe) data_hi++;
      end else if (run_len != 0) begin
         inh_len     = run_len;
         inh_hi      = data_hi;
         inh_last    = last_data;
         release_cyc = cyc;
         inh_runs++;
         run_len = 0;
         data_hi = 0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Reference: the ten bits the device samples, LSB-first data, odd parity, stop.
   function automatic logic [9:0] expect_bits(input logic [7:0] b);
      logic [9:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[i];
      r[8] = (($countones(b) % 2) == 0);
      r[9] = 1'b1;
      return r;
   endfunction

   task automatic send(input logic [7:0] b);
      int g = 0;
      while (!host.tx_ready && g < 500) begin
         tick();
         g++;
      end
      check("ready_before_send", host.tx_ready, 1);
      host.tx_valid = 1'b1;
      host.tx_data  = b;
      tick();
      host.tx_valid = 1'b0;
   endtask

   // Device side: wait for clock release, check start bit, clock 11 bits, optional ACK.
   task automatic device_frame(input int runs0, input bit ack, input int abort_at,
                               output logic [9:0] smp);
      int g = 0;
      smp = '0;
      while (inh_runs == runs0 && g < 1000) begin
         tick();
         g++;
      end
      check("release_seen", (inh_runs != runs0), 1);
      repeat (5) tick();
      check("start_bit", data_line, 0);
      for (int i = 1; i <= 11; i++) begin
         if (i == 11 && ack) dev_data = 1'b0;
         dev_clk = 1'b0;
         if (i == abort_at) begin
            repeat (HALF / 2) tick();
            return;
         end
         repeat (HALF) tick();
         if (i <= 10) smp[i-1] = data_line;
         dev_clk = 1'b1;
         if (i == 11) dev_data = 1'b1;
         repeat (HALF) tick();
      end
   endtask

   task automatic run_ack(input logic [7:0] b);
      int d0, e0, r0;
      logic [9:0] smp;
      d0 = done_cnt;
      e0 = err_cnt;
      r0 = inh_runs;
      send(b);
      check("busy_in_frame", host.busy, 1);
      check("not_ready_in_frame", host.tx_ready, 0);
      device_frame(r0, 1'b1, 0, smp);
      check("frame_bits", smp, expect_bits(b));
      check("inhibit_len", inh_len, INH);
      check("start_on_last_inhibit", inh_last, 1);
      check("start_only_last_inhibit", inh_hi, 1);
      repeat (10) tick();
      check("done_once", done_cnt, d0 + 1);
      check("no_err", err_cnt, e0);
      check("busy_low_at_done", done_busy, 0);
   endtask

   initial begin
      logic [9:0] smp, smp2;
      logic [7:0] b;
      int d0, e0, r0, g;

      host.tx_valid = 1'b0;
      host.tx_data  = 8'h00;

      // Reset state
      repeat (3) tick();
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_busy", host.busy, 0);
      check("rst_done_err", {host.tx_done, host.tx_err}, 0);
      sys_rst_n = 1'b1;
      tick();
      check("ready_after_rst", host.tx_ready, 1);

      // LED command, then parity boundary cases, then random bytes
      run_ack(PS2_CMD_SET_LED);
      run_ack(8'h00);
      run_ack(8'h01);
      for (int n = 0; n < 4; n++) begin
         b = 8'($urandom);
         run_ack(b);
      end

      // NACK at edge 11
      b  = 8'($urandom);
      d0 = done_cnt;
      e0 = err_cnt;
      r0 = inh_runs;
      send(b);
      device_frame(r0, 1'b0, 0, smp);
      check("nack_bits", smp, expect_bits(b));
`ifdef PS2_HOST_TX_RETRY_EN
      device_frame(r0 + 1, 1'b0, 0, smp2);
      check("retry_inhibit_len", inh_len, INH);
      check("retry_same_bits", smp2, expect_bits(b));
`endif
      repeat (10) tick();
      check("nack_err_once", err_cnt, e0 + 1);
      check("nack_no_done", done_cnt, d0);
      check("nack_oe_released", err_oe, 2'b00);

      // Device never clocks: timeout
      d0 = done_cnt;
      e0 = err_cnt;
      r0 = inh_runs;
      send(8'($urandom));
      g = 0;
      while (err_cnt == e0 && g < 6000) begin
         tick();
         g++;
      end
      check("tmo_err_seen", err_cnt, e0 + 1);
      check("tmo_latency", err_cyc - release_cyc, TMO);
      check("tmo_no_done", done_cnt, d0);
`ifdef PS2_HOST_TX_RETRY_EN
      check("tmo_inhibit_runs", inh_runs, r0 + 2);
`else
      check("tmo_inhibit_runs", inh_runs, r0 + 1);
`endif
      repeat (5) tick();

      // Asynchronous reset in the middle of bit 4
      d0 = done_cnt;
      e0 = err_cnt;
      r0 = inh_runs;
      send(8'h00);
      device_frame(r0, 1'b1, 4, smp);
      check("bit4_data_driven", ps2_data_oe, 1);
      #1 sys_rst_n = 1'b0;
      #1;
      check("async_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      check("async_rst_busy", host.busy, 0);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (3) tick();
      sys_rst_n = 1'b1;
      tick();
      check("ready_after_async_rst", host.tx_ready, 1);
      check("abort_no_pulse", {done_cnt, err_cnt}, {d0, e0});
      run_ack(PS2_CMD_RESET);

      // tx_valid held through a frame with tx_data changed after acceptance
      d0 = done_cnt;
      r0 = inh_runs;
      host.tx_valid = 1'b1;
      host.tx_data  = 8'h3C;
      tick();
      host.tx_data = 8'hC5;
      device_frame(r0, 1'b1, 0, smp);
      host.tx_valid = 1'b0;
      check("held_first_bits", smp, expect_bits(8'h3C));
      check("held_second_after_ready", inh_start_cyc, done_cyc + 1);
      device_frame(r0 + 1, 1'b1, 0, smp2);
      check("held_second_bits", smp2, expect_bits(8'hC5));
      repeat (10) tick();
      check("held_two_done", done_cnt, d0 + 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
